// File: rtl/bit32_ripple_carry_adder_unit.sv
// 32-bit ripple-carry adder with carry-in; sum, carry-out and signed overflow
// are registered, giving one cycle of latency and one result per cycle.

module bit32_rca_full_adder (
    input  logic a_in,
    input  logic b_in,
    input  logic c_in,
    output logic s_out,
    output logic c_out
);

    logic p;

    assign p     = a_in ^ b_in;
    assign s_out = p ^ c_in;
    assign c_out = (a_in & b_in) | (c_in & p);

endmodule

module bit32_ripple_carry_adder_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] A_in,
    input  logic [31:0] B_in,
    input  logic        C_in,
    output logic [31:0] S_out,
    output logic        C_out,
    output logic        V_out
);

    logic [32:0] carry;
    logic [31:0] sum_w;

    logic [31:0] s_d, s_q;
    logic        c_d, c_q;
    logic        v_d, v_q;

    assign carry[0] = C_in;

    // Carry ripples bit by bit; each stage only sees its neighbour's carry.
    for (genvar i = 0; i < 32; i++) begin : g_fa
        bit32_rca_full_adder u_fa (
            .a_in  (A_in[i]),
            .b_in  (B_in[i]),
            .c_in  (carry[i]),
            .s_out (sum_w[i]),
            .c_out (carry[i+1])
        );
    end

    always_comb begin
        s_d = sum_w;
        c_d = carry[32];
        v_d = carry[32] ^ carry[31];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_q <= 32'h0;
            c_q <= 1'b0;
            v_q <= 1'b0;
        end else begin
            s_q <= s_d;
            c_q <= c_d;
            v_q <= v_d;
        end
    end

    assign S_out = s_q;
    assign C_out = c_q;
    assign V_out = v_q;

endmodule

// File: tb/tb_bit32_ripple_carry_adder_unit.sv
// Scoreboard bench for the registered 32-bit adder: stimulus pushes expected
// results, an independent monitor pops one per clock and compares.

module tb_bit32_ripple_carry_adder_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] A_in;
    logic [31:0] B_in;
    logic        C_in;
    logic [31:0] S_out;
    logic        C_out;
    logic        V_out;

    typedef struct {
        logic [31:0] s;
        logic        c;
        logic        v;
        string       tag;
    } exp_t;

    exp_t exp_q[$];

    int unsigned checks = 0;
    int unsigned errors = 0;

    bit32_ripple_carry_adder_unit dut (
        .clk   (clk),
        .rst_n (rst_n),
        .A_in  (A_in),
        .B_in  (B_in),
        .C_in  (C_in),
        .S_out (S_out),
        .C_out (C_out),
        .V_out (V_out)
    );

    always #5 clk = ~clk;

    // Reference: plain 33-bit addition; overflow from operand/result signs.
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                   input logic ci, input string tag);
        exp_t        e;
        logic [32:0] full;
        full  = {1'b0, a} + {1'b0, b} + {32'h0, ci};
        e.s   = full[31:0];
        e.c   = full[32];
        e.v   = (a[31] == b[31]) && (full[31] != a[31]);
        e.tag = tag;
        return e;
    endfunction

    task automatic drive(input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input string tag);
        @(negedge clk);
        A_in = a;
        B_in = b;
        C_in = ci;
        exp_q.push_back(model(a, b, ci, tag));
    endtask

    task automatic check_zero(input string tag);
        checks++;
        if (S_out !== 32'h0 || C_out !== 1'b0 || V_out !== 1'b0) begin
            errors++;
            $display("FAIL %s got S=%h C=%b V=%b exp S=00000000 C=0 V=0",
                     tag, S_out, C_out, V_out);
        end
    endtask

    // Reset pulse between edges with a fresh vector on the inputs.
    task automatic reset_pulse(input logic [31:0] a, input logic [31:0] b,
                               input logic ci);
        @(negedge clk);
        A_in = a;
        B_in = b;
        C_in = ci;
        #1 rst_n = 1'b0;
        exp_q.delete();
        #1 check_zero("rst_midstream");
        #1 rst_n = 1'b1;
        exp_q.push_back(model(a, b, ci, "post_reset"));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n === 1'b1 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if (S_out !== e.s || C_out !== e.c || V_out !== e.v) begin
                    errors++;
                    $display("FAIL %s got S=%h C=%b V=%b exp S=%h C=%b V=%b",
                             e.tag, S_out, C_out, V_out, e.s, e.c, e.v);
                end
            end
        end
    end

    initial begin : stimulus
        logic [31:0] a, b;
        logic        ci;
        int unsigned waited;

        rst_n = 1'b1;
        A_in  = 32'hDEAD_BEEF;
        B_in  = 32'h1234_5678;
        C_in  = 1'b1;
        #1 rst_n = 1'b0;
        #2 check_zero("rst_async");
        @(posedge clk);
        #1 check_zero("rst_hold_edge");
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.push_back(model(A_in, B_in, C_in, "rst_release"));

        drive(32'd15,         32'd49,         1'b1, "basic");
        drive(32'hFFFF_FFFF,  32'h0,          1'b1, "full_ripple");
        drive(32'h7FFF_FFFF,  32'h1,          1'b0, "pos_overflow");
        drive(32'h8000_0000,  32'h8000_0000,  1'b0, "neg_overflow");
        drive(32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b1, "all_ones_cin");
        drive(32'h0,          32'h0,          1'b1, "zero_cin");
        drive(32'h0,          32'h0,          1'b0, "zero");
        drive(32'h8000_0000,  32'h7FFF_FFFF,  1'b1, "mixed_sign_wrap");

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(3))
                0: begin a = $urandom; b = $urandom; end
                1: begin a = $urandom; b = ~a; end
                2: begin a = {1'b0, 31'($urandom)}; b = {1'b0, 31'($urandom)}; end
                default: begin a = {1'b1, 31'($urandom)}; b = {1'b1, 31'($urandom)}; end
            endcase
            ci = 1'($urandom);
            drive(a, b, ci, "random");
            if (i == 100 || i == 200)
                reset_pulse($urandom, $urandom, 1'($urandom));
        end

        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending exp 0", exp_q.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
